// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through stream FIFO with level flags and sticky overflow
module stream_fifo #(
  parameter int Width            = 8,
  parameter int DepthBits        = 4,
  parameter int AlmostFullLevel  = (2 ** DepthBits) - 1,
  parameter int AlmostEmptyLevel = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 write_valid,
  input  logic [Width-1:0]     write_data,
  output logic                 write_ready,
  output logic                 read_valid,
  output logic [Width-1:0]     read_data,
  input  logic                 read_ready,
  output logic [DepthBits:0]   count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow
);

  localparam int Depth = 2 ** DepthBits;
  localparam logic [DepthBits:0] DepthCount = (DepthBits + 1)'(Depth);
  localparam logic [DepthBits:0] AfLevel    = (DepthBits + 1)'(AlmostFullLevel);
  localparam logic [DepthBits:0] AeLevel    = (DepthBits + 1)'(AlmostEmptyLevel);
  localparam logic [DepthBits:0] PtrOne     = (DepthBits + 1)'(1);

  logic [Width-1:0]   mem_q [Depth];
  logic [DepthBits:0] wr_ptr_q, wr_ptr_d;
  logic [DepthBits:0] rd_ptr_q, rd_ptr_d;
  logic [DepthBits:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               write_accept;
  logic               read_accept;

  // Handshake flags come only from registered count, so read_ready never reaches write_ready.
  assign write_ready  = (count_q != DepthCount);
  assign read_valid   = (count_q != '0);
  assign write_accept = write_valid && write_ready;
  assign read_accept  = read_valid && read_ready;

  assign read_data    = mem_q[rd_ptr_q[DepthBits-1:0]];
  assign count        = count_q;
  assign almost_full  = (count_q >= AfLevel);
  assign almost_empty = (count_q <= AeLevel);
  assign overflow     = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (write_accept) wr_ptr_d = wr_ptr_q + PtrOne;
      if (read_accept)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({write_accept, read_accept})
        2'b10:   count_d = count_q + PtrOne;
        2'b01:   count_d = count_q - PtrOne;
        default: count_d = count_q;
      endcase
      if (write_valid && !write_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left out of reset; a flush only moves pointers.
  always_ff @(posedge clk) begin
    if (write_accept && !clear) mem_q[wr_ptr_q[DepthBits-1:0]] <= write_data;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter: Width, default 8, data word width in bits (>=1).
REQ-002 Parameter: DepthBits, default 4, log2 of storage depth; Depth = 2**DepthBits (>=1).
REQ-003 Parameter: AlmostFullLevel, default Depth-1, count at or above which almost_full asserts (1..Depth).
REQ-004 Parameter: AlmostEmptyLevel, default 1, count at or below which almost_empty asserts (0..Depth-1).
REQ-005 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  synchronous flush; empties the FIFO.
REQ-009 write_valid  input  1  producer offers write_data.
REQ-010 write_data  input  Width  word to store.
REQ-011 write_ready  output  1  FIFO can accept a word this cycle.
REQ-012 read_valid  output  1  read_data holds the oldest stored word.
REQ-013 read_data  output  Width  oldest word, first-word-fall-through.
REQ-014 read_ready  input  1  consumer takes read_data this cycle.
REQ-015 count  output  DepthBits+1  number of stored words, 0..Depth.
REQ-016 almost_full  output  1  count >= AlmostFullLevel.
REQ-017 almost_empty  output  1  count <= AlmostEmptyLevel.
REQ-018 overflow  output  1  sticky: a write was offered while write_ready was low.

Function
REQ-019 Storage SHALL hold exactly Depth words; all Depth entries usable (no sacrificed slot).
REQ-020 Read and write pointers SHALL be DepthBits+1 bits; low DepthBits address memory, MSB disambiguates full/empty; pointers wrap modulo 2*Depth.
REQ-021 write_ready SHALL equal (count != Depth), purely from registered state, with no combinational path from read_ready.
REQ-022 read_valid SHALL equal (count != 0), purely from registered state.
REQ-023 Write accepted iff write_valid && write_ready; word stored at write pointer, write pointer +1 at the clock edge.
REQ-024 Read accepted iff read_valid && read_ready; read pointer +1 at the clock edge.
REQ-025 read_data SHALL be memory at the read pointer combinationally; value unspecified while read_valid=0.
REQ-026 Latency: a word written into an empty FIFO at edge N SHALL appear with read_valid=1 immediately after edge N (no same-cycle bypass).
REQ-027 count next = count + write_accept - read_accept; simultaneous accept leaves count unchanged.
REQ-028 When full, write_ready=0 even if read_ready=1 in the same cycle; no write that cycle.
REQ-029 When empty, a write_valid does not produce read_valid in the same cycle.
REQ-030 overflow SHALL set at the edge where write_valid=1 && write_ready=0 and hold until clear or reset.
REQ-031 clear=1 SHALL, at the edge, zero both pointers, count and overflow; clear overrides any write/read accepted that cycle (neither takes effect).
REQ-032 almost_full and almost_empty SHALL be derived from count combinationally and track it cycle-for-cycle.
REQ-033 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-034 reset_n=0 SHALL asynchronously force pointers=0, count=0, overflow=0, without waiting for clk.
REQ-035 During and after reset: write_ready=1, read_valid=0, almost_empty=1, almost_full=0, overflow=0; read_data unspecified.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 Reset asserted mid-operation SHALL discard all stored words; first post-reset write behaves as into an empty FIFO.
REQ-038 Deassertion of reset_n SHALL be synchronised externally; the block's first accepted operation is at the first edge after deassertion.

Verification (Width=8, DepthBits=2, AlmostFullLevel=3, AlmostEmptyLevel=1)
REQ-039 Write 0x11,0x22,0x33,0x44 on 4 edges, read_ready=0 -> count 1,2,3,4; almost_full at count 3; write_ready=0 at count 4; read_data=0x11.
REQ-040 Full FIFO, write_valid=1 write_data=0x55, read_ready=1 one cycle -> 0x11 popped, 0x55 not stored, count=3, overflow=1 and sticky.
REQ-041 Empty FIFO, write_valid=1 0xA5 with read_ready=1 -> read_valid=0 that cycle; next cycle read_valid=1, read_data=0xA5, count=1.
REQ-042 Count=2, simultaneous write 0x66 and read -> count stays 2; 10 cycles continuous push/pop of 0x00..0x09 across wrap -> outputs in order, no loss.
REQ-043 Count=3 with overflow=1, assert clear with write_valid=1 -> count=0, read_valid=0, overflow=0, written word discarded.
REQ-044 Count=2, pulse reset_n low between clock edges -> count=0, read_valid=0, write_ready=1 immediately, before next edge.
